multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle main control FSM for the MIPS datapath. It replaces the single-cycle opcode decoder with a sequenced controller that steps each instruction through fetch, decode, execute, memory and write-back states. Memory accesses wait on a ready handshake with a bounded wait counter. It supports a wider opcode set (bne, andi, slti) and traps on illegal opcodes or memory timeout. The block sits between the instruction register opcode field and the shared-memory multi-cycle datapath muxes and enables.

## Interface
- WAIT_LIMIT, 15: maximum wait cycles per memory access before the trap fires (1..2^CNT_W−1).
- CNT_W, 4: width of the memory wait counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  leave IDLE and start fetching; sampled only in IDLE.
- Instruction  in  6  opcode field, IR[31:26]; sampled in DECODE.
- Zero  in  1  ALU zero flag; used in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA  out  1 each  datapath enables and selects.
- RegDst, MemtoReg  out  2 each  0 selects rt / ALUOut, 1 selects rd / MDR, 2 selects $31 / PC.
- ALUSrcB  out  2  0 selects B, 1 selects constant 4, 2 selects sign-extended immediate, 3 selects shifted immediate.
- PCSource  out  2  0 selects ALU result, 1 selects ALUOut, 2 selects jump target.
- ALUOp  out  3  0 add, 1 sub, 2 funct, 3 or, 4 and, 5 slt.
- illegal_op, mem_timeout  out  1 each  sticky trap causes.
- state  out  4  current state code, for debug.

## Operation
- State codes:
  - IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6.
  - EXEC 7, ALUWB 8, BRANCH 9, IMMEXEC 10, IMMWB 11, JUMP 12, JAL 13, TRAP 15.
- Outputs are Moore, decoded from the registered state. Exception: IRWrite and PCWrite in FETCH are qualified by mem_ready. Every output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. When mem_ready=1, assert IRWrite=1 and PCWrite=1 that cycle and go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target). Dispatch on Instruction:
  - 35/43 → MEMADR; 0 → EXEC; 4/5 → BRANCH.
  - 8/10/12/13 → IMMEXEC; 2 → JUMP; 3 → JAL.
  - Any other opcode → TRAP with illegal_op set.
  - The opcode is latched internally in DECODE for use in later states.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. On mem_ready go to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Go to FETCH.
- MEMWR: MemWrite=1, IorD=1. On mem_ready go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2. Then ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, BranchNe=(opcode==5). Go to FETCH. The PC update condition is Zero^BranchNe, applied in the datapath.
- IMMEXEC: ALUSrcA=1, ALUSrcB=2. ALUOp is 0 for addi, 5 for slti, 4 for andi, 3 for ori. Then IMMWB: RegWrite=1, RegDst=0, MemtoReg=0. Then FETCH.
- JUMP: PCWrite=1, PCSource=2. Go to FETCH.
- JAL: PCWrite=1, PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2. Go to FETCH. The PC value written to $31 is the already-incremented PC.
- Wait counter:
  - Clears on every state change.
  - Increments each cycle that FETCH, MEMRD or MEMWR is held with mem_ready=0.
  - When the counter equals WAIT_LIMIT and mem_ready=0, go to TRAP and set mem_timeout.
  - mem_ready=1 in the limit cycle wins: the access completes normally.
- TRAP: all datapath outputs 0. illegal_op and mem_timeout hold their values. TRAP exits only via rst_n.

## Timing
- Reset:
  - Asynchronous on rst_n falling.
  - state=IDLE, counter=0, illegal_op=0, mem_timeout=0, all outputs 0.
  - First transition is on the first clk edge with rst_n high.
- Reset mid-instruction aborts immediately: outputs go to 0 asynchronously, with no partial write-back afterwards.
- Cycle counts from FETCH entry with zero-wait memory:
  - lw 5, sw 4, R-type 4, immediate 4, beq/bne 3, j 3, jal 3.
  - Each wait cycle adds 1.
- Memory requests (MemRead or MemWrite) stay stable from state entry until the mem_ready cycle.
- Instruction is ignored outside DECODE.
- run is ignored outside IDLE. The FSM never returns to IDLE except through reset.

## Test plan
- Reset, then run=1 with mem_ready always 1, fetching lw (op 35) → state sequence 1,2,3,4,5,1. MemtoReg=1 and RegWrite=1 in state 5 only.
- beq with Zero=1, then bne with Zero=1 → PCWriteCond=1 in BRANCH both times. BranchNe=0 for beq and 1 for bne, giving PC update for beq and none for bne.
- jal (op 3) → JAL state shows RegDst=2, MemtoReg=2, RegWrite=1, PCWrite=1, PCSource=2. Back in FETCH on the next cycle.
- sw with mem_ready low for 3 cycles in MEMWR → MemWrite=1 held for 4 cycles, then FETCH, mem_timeout=0.
- Fetch with mem_ready stuck at 0 and WAIT_LIMIT=15 → TRAP entered 16 cycles after FETCH entry, mem_timeout=1, all enables 0. Rerun with mem_ready=1 on the limit cycle → no trap.
- Opcode 63 in DECODE → TRAP, illegal_op=1 sticky. Assert rst_n=0 mid-TRAP → state=0 and flags=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control-to-datapath bundle for the multi-cycle MIPS controller.
// master = controller, slave = datapath side.
interface multicycle_control_if;
  logic       run;
  logic [5:0] Instruction;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [2:0] ALUOp;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state;

  modport master (
    input  run, Instruction, Zero, mem_ready,
    output PCWrite, PCWriteCond, BranchNe, IorD,
    output MemRead, MemWrite, IRWrite, RegWrite,
    output ALUSrcA, RegDst, MemtoReg, ALUSrcB,
    output PCSource, ALUOp,
    output illegal_op, mem_timeout, state
  );

  modport slave (
    output run, Instruction, Zero, mem_ready,
    input  PCWrite, PCWriteCond, BranchNe, IorD,
    input  MemRead, MemWrite, IRWrite, RegWrite,
    input  ALUSrcA, RegDst, MemtoReg, ALUSrcB,
    input  PCSource, ALUOp,
    input  illegal_op, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with bounded
// memory wait and sticky trap causes.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input logic clk,
  input logic rst_n,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_IMMEXEC = 4'd10,
    S_IMMWB   = 4'd11,
    S_JUMP    = 4'd12,
    S_JAL     = 4'd13,
    S_TRAP    = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0] op_q, op_d;
  logic       ill_q, ill_d;
  logic       to_q, to_d;
  logic       mem_st;
  logic       at_lim;

  assign mem_st = (state_q == S_FETCH) ||
                  (state_q == S_MEMRD) ||
                  (state_q == S_MEMWR);
  assign at_lim = (cnt_q == CNT_W'(WAIT_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    ill_d           = ill_q;
    to_d            = to_q;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.RegDst      = 2'd0;
    bus.MemtoReg    = 2'd0;
    bus.ALUSrcB     = 2'd0;
    bus.PCSource    = 2'd0;
    bus.ALUOp       = 3'd0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'd1;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = S_DECODE;
        end else if (at_lim) begin
          to_d    = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        bus.ALUSrcB = 2'd3;
        op_d        = bus.Instruction;
        case (bus.Instruction)
          6'd35, 6'd43: state_d = S_MEMADR;
          6'd0:         state_d = S_EXEC;
          6'd4, 6'd5:   state_d = S_BRANCH;
          6'd8, 6'd10,
          6'd12, 6'd13: state_d = S_IMMEXEC;
          6'd2:         state_d = S_JUMP;
          6'd3:         state_d = S_JAL;
          default: begin
            ill_d   = 1'b1;
            state_d = S_TRAP;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        state_d = (op_q == 6'd35) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEMWB;
        end else if (at_lim) begin
          to_d    = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = 2'd1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_FETCH;
        end else if (at_lim) begin
          to_d    = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 3'd2;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'd1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 3'd1;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'd1;
        bus.BranchNe    = (op_q == 6'd5);
        state_d         = S_FETCH;
      end
      S_IMMEXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'd2;
        unique case (1'b1)
          op_q == 6'd10: bus.ALUOp = 3'd5;
          op_q == 6'd12: bus.ALUOp = 3'd4;
          op_q == 6'd13: bus.ALUOp = 3'd3;
          default:       bus.ALUOp = 3'd0;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'd2;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'd2;
        bus.RegWrite = 1'b1;
        bus.RegDst   = 2'd2;
        bus.MemtoReg = 2'd2;
        state_d      = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Counter restarts on every state change so each access gets its own budget
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = '0;
    else if (mem_st && !bus.mem_ready)
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign bus.state       = state_q;
  assign bus.illegal_op  = ill_q;
  assign bus.mem_timeout = to_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a
// trace-generating instruction-level reference model.
module tb_multicycle_control;
  localparam int LIM = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  multicycle_control_if bus();

  multicycle_control #(.WAIT_LIMIT(LIM), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, rw, asa;
    logic [1:0] rd, m2r, asb, pcs;
    logic [2:0] aop;
  } ctl_t;

  typedef struct {
    int st; bit mr; bit run; bit zero;
    logic [5:0] op; bit ill; bit to;
  } rec_t;

  rec_t q[$];
  bit exp_ill, exp_to;
  logic [5:0] cur_op;
  logic [5:0] legal [11] =
    '{6'd35, 6'd43, 6'd0, 6'd4, 6'd5, 6'd8,
      6'd10, 6'd12, 6'd13, 6'd2, 6'd3};

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic void push(int st, bit mr,
                               bit run = 1'b0,
                               bit zero = 1'b0);
    rec_t r;
    r.st = st; r.mr = mr; r.run = run;
    r.zero = zero; r.op = cur_op;
    r.ill = exp_ill; r.to = exp_to;
    q.push_back(r);
  endfunction

  function automatic void traps(int n);
    for (int i = 0; i < n; i++)
      push(15, 1'($urandom));
  endfunction

  // Memory access lasting w wait cycles; 1 if it timed out
  function automatic bit access(int st, int w);
    for (int i = 0; i <= w; i++) begin
      if (i == w) begin
        push(st, 1'b1);
        return 1'b0;
      end
      push(st, 1'b0);
      if (i == LIM) begin
        exp_to = 1'b1;
        traps(3);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit is_legal(logic [5:0] op);
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void gen(logic [5:0] op, int wf,
                              int wm, bit zero);
    if (access(1, wf)) return;
    cur_op = op;
    push(2, 1'($urandom));
    if (!is_legal(op)) begin
      exp_ill = 1'b1;
      traps(4);
      return;
    end
    case (op)
      6'd35: begin
        push(3, 1'($urandom));
        if (access(4, wm)) return;
        push(5, 1'($urandom));
      end
      6'd43: begin
        push(3, 1'($urandom));
        void'(access(6, wm));
      end
      6'd0: begin
        push(7, 1'($urandom));
        push(8, 1'($urandom));
      end
      6'd4, 6'd5: push(9, 1'($urandom), 1'b0, zero);
      6'd2: push(12, 1'($urandom));
      6'd3: push(13, 1'($urandom));
      default: begin
        push(10, 1'($urandom));
        push(11, 1'($urandom));
      end
    endcase
  endfunction

  function automatic ctl_t exp_ctl(rec_t r);
    ctl_t c = '0;
    case (r.st)
      1: begin
        c.mrd = 1; c.asb = 1;
        c.irw = r.mr; c.pcw = r.mr;
      end
      2: c.asb = 3;
      3: begin c.asa = 1; c.asb = 2; end
      4: begin c.mrd = 1; c.iord = 1; end
      5: begin c.rw = 1; c.m2r = 1; end
      6: begin c.mwr = 1; c.iord = 1; end
      7: begin c.asa = 1; c.aop = 2; end
      8: begin c.rw = 1; c.rd = 1; end
      9: begin
        c.asa = 1; c.aop = 1; c.pcwc = 1;
        c.pcs = 1; c.bne = (r.op == 6'd5);
      end
      10: begin
        c.asa = 1; c.asb = 2;
        c.aop = (r.op == 6'd10) ? 3'd5 :
                (r.op == 6'd12) ? 3'd4 :
                (r.op == 6'd13) ? 3'd3 : 3'd0;
      end
      11: c.rw = 1;
      12: begin c.pcw = 1; c.pcs = 2; end
      13: begin
        c.pcw = 1; c.pcs = 2; c.rw = 1;
        c.rd = 2; c.m2r = 2;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic ctl_t obs();
    ctl_t c;
    c.pcw = bus.PCWrite; c.pcwc = bus.PCWriteCond;
    c.bne = bus.BranchNe; c.iord = bus.IorD;
    c.mrd = bus.MemRead; c.mwr = bus.MemWrite;
    c.irw = bus.IRWrite; c.rw = bus.RegWrite;
    c.asa = bus.ALUSrcA; c.rd = bus.RegDst;
    c.m2r = bus.MemtoReg; c.asb = bus.ALUSrcB;
    c.pcs = bus.PCSource; c.aop = bus.ALUOp;
    return c;
  endfunction

  task automatic play();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(negedge clk);
      bus.run = (r.st == 0) ? r.run : 1'($urandom);
      bus.Instruction = (r.st == 2) ? r.op : 6'($urandom);
      bus.Zero = (r.st == 9) ? r.zero : 1'($urandom);
      bus.mem_ready = r.mr;
      #1;
      check("state", 32'(bus.state), 32'(r.st));
      check("ctl", 32'(obs()), 32'(exp_ctl(r)));
      check("flags", {30'd0, bus.illegal_op, bus.mem_timeout},
            {30'd0, r.ill, r.to});
      if (r.st == 9)
        check("pcupd",
              32'((bus.Zero ^ bus.BranchNe) & bus.PCWriteCond),
              32'(r.zero ^ (r.op == 6'd5)));
    end
  endtask

  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_st"}, 32'(bus.state), 32'd0);
    check({tag, "_ctl"}, 32'(obs()), 32'd0);
    check({tag, "_fl"}, {30'd0, bus.illegal_op, bus.mem_timeout}, 32'd0);
    exp_ill = 1'b0; exp_to = 1'b0;
    bus.run = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bus.run = 1'b0; bus.Instruction = '0;
    bus.Zero = 1'b0; bus.mem_ready = 1'b0;
    exp_ill = 1'b0; exp_to = 1'b0; cur_op = '0;
    #1;
    check("rst_st", 32'(bus.state), 32'd0);
    check("rst_ctl", 32'(obs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    push(0, 1'b1, 1'b0); push(0, 1'b0, 1'b0);
    push(0, 1'b0, 1'b1);
    gen(6'd35, 0, 0, 1'b0);
    gen(6'd4, 0, 0, 1'b1);
    gen(6'd5, 0, 0, 1'b1);
    gen(6'd3, 0, 0, 1'b0);
    gen(6'd43, 0, 3, 1'b0);
    for (int i = 0; i < 60; i++)
      gen(legal[$urandom_range(0, 10)],
          $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom));
    gen(6'd0, LIM, 0, 1'b0);
    gen(6'd35, 0, LIM, 1'b0);
    gen(6'd43, 0, LIM, 1'b0);
    gen(6'd0, LIM + 1, 0, 1'b0);
    play();
    async_reset("rst_to");

    push(0, 1'b0, 1'b1);
    gen(6'd8, 1, 0, 1'b0);
    gen(6'd35, 0, LIM + 1, 1'b0);
    play();
    async_reset("rst_memto");

    push(0, 1'b0, 1'b1);
    gen(6'd63, 0, 0, 1'b0);
    play();
    async_reset("rst_ill");

    push(0, 1'b0, 1'b1);
    push(1, 1'b1);
    cur_op = 6'd35;
    push(2, 1'b0); push(3, 1'b0);
    push(4, 1'b0); push(4, 1'b0);
    play();
    async_reset("rst_mid");
    push(0, 1'b1, 1'b0); push(0, 1'b1, 1'b0);
    play();

    n = 0;
    repeat (3) begin
      push(0, 1'b0, 1'b1);
      gen(6'($urandom), 0, 0, 1'b0);
      play();
      async_reset("rst_rnd");
      n++;
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
